// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared state encoding and width defaults for the memory loader and timingCore
package mem_loader_pkg;
    localparam int CORE_WORD_W = 17;
    localparam int ADDR_W_DEF  = 9;
    localparam int DATA_W_DEF  = CORE_WORD_W;
    localparam int SEL_W_DEF   = 3;
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FILL     = 2'd1,
        NEXT_MEM = 2'd2,
        DONE     = 2'd3
    } state_e;
endpackage

// File: rtl/mem_loader_req_ctl.sv
// mem_loader_req_ctl: merges start/update-edge requests and holds at most one pending request while busy
module mem_loader_req_ctl
    import mem_loader_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic update_mem_i,
    input  logic idle_i,
    input  logic abort_i,
    output logic req_o
);
    logic upd_prev_q, pend_q, pend_d, new_req;
    assign new_req = start_i | (update_mem_i & ~upd_prev_q);
    assign req_o   = idle_i & (new_req | pend_q);
    // Any request seen in IDLE is taken at once, so pending only accumulates while busy.
    assign pend_d  = (abort_i | idle_i) ? 1'b0 : (pend_q | new_req);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_prev_q <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            upd_prev_q <= update_mem_i;
            pend_q     <= pend_d;
        end
    end
endmodule

// File: rtl/mem_loader.sv
// mem_loader: streams words into NUM_MEMS core memories per request; LOADER_TIMEOUT_EN adds a stall abort with sticky error_o
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int SEL_W          = SEL_W_DEF,
    parameter int NUM_MEMS       = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              update_mem_i,
    input  logic [9:0]        points_per_line_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              we_o,
    output logic [SEL_W-1:0]  memory_selector_o,
    output logic              mem_updated_o,
    output logic              busy_o,
    output logic              error_o
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, last_q, last_d, waddr_q;
    logic [SEL_W-1:0]  sel_q, sel_d, msel_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ready_q, we_q, req, accept, timeout, unused_ppl;

    assign accept     = s_valid_i & ready_q;
    assign unused_ppl = ^points_per_line_i;

    mem_loader_req_ctl u_req_ctl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .update_mem_i (update_mem_i),
        .idle_i       (state_q == IDLE),
        .abort_i      (timeout),
        .req_o        (req)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               error_q;
    assign timeout = (state_q == FILL) & ~s_valid_i & (stall_q == STALL_W'(TIMEOUT_CYCLES - 1));
    assign stall_d = ((state_q == FILL) & ~s_valid_i & ~timeout) ? stall_q + 1'b1 : '0;
    assign error_o = error_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
            error_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
            error_q <= error_q | timeout;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
    assign error_o = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = FILL;
                last_d  = points_per_line_i[ADDR_W-1:0];
                addr_d  = '0;
                sel_d   = '0;
            end
            FILL: if (timeout) begin
                state_d = IDLE;
            end else if (accept) begin
                addr_d  = addr_q + 1'b1;
                state_d = (addr_q == last_q) ? NEXT_MEM : FILL;
            end
            NEXT_MEM: if (sel_q == SEL_W'(NUM_MEMS - 1)) begin
                state_d = DONE;
            end else begin
                state_d = FILL;
                sel_d   = sel_q + 1'b1;
                addr_d  = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            last_q  <= '0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            msel_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            // Registered ready follows the next state, so it drops right after a memory's last word.
            ready_q <= (state_d == FILL);
            we_q    <= accept;
            if (accept) begin
                waddr_q <= addr_q;
                wdata_q <= s_data_i;
                msel_q  <= sel_q;
            end
        end
    end

    assign s_ready_o         = ready_q;
    assign we_o              = we_q;
    assign waddr_o           = waddr_q;
    assign wdata_o           = wdata_q;
    assign memory_selector_o = msel_q;
    assign mem_updated_o     = (state_q == DONE);
    assign busy_o            = (state_q != IDLE);
endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Upstream feeder for the timing core's pixel/timestamp memories.
- Streams 17-bit words from a host-side valid/ready source and writes them into NUM_MEMS memories, each with points_per_line_i+1 words, over the core's waddr/wdata/we/memory_selector write port.
- Answers the core's update_mem request with a one-cycle mem_updated pulse once every word is written.
- Sits between the AXI/FIFO host interface and timingCore.

Parameters:
- ADDR_W, 9, write address width (matches core waddr).
- DATA_W, 17, word width (matches core wdata).
- SEL_W, 3, memory selector width.
- NUM_MEMS, 2, memories filled per update, selectors 0..NUM_MEMS-1 in order; legal range 1..2^SEL_W.
- TIMEOUT_CYCLES, 1024, stall limit used only with LOADER_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  one-cycle pulse: initial preload request.
- update_mem_i  in  1  update request from core (update_mem_o); rising edge is a request.
- points_per_line_i  in  10  last address per memory; sampled at load start.
- s_data_i  in  DATA_W  stream data.
- s_valid_i  in  1  stream valid.
- s_ready_o  out  1  stream ready.
- waddr_o  out  ADDR_W  write address to core.
- wdata_o  out  DATA_W  write data to core.
- we_o  out  1  write enable to core.
- memory_selector_o  out  SEL_W  target memory.
- mem_updated_o  out  1  one-cycle completion pulse to core.
- busy_o  out  1  load in progress.
- error_o  out  1  sticky timeout flag (constant 0 without macro).

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: all outputs 0. State IDLE. Counters and pending flag cleared. Reset mid-load aborts immediately with no mem_updated pulse.
- FSM states: IDLE, FILL, NEXT_MEM, DONE.
  - IDLE -> FILL on start_i, an update_mem_i rising edge, or pending=1.
    - On entry: latch last_addr = points_per_line_i[ADDR_W-1:0] (upper bit ignored), addr_cnt=0, sel_cnt=0, clear pending.
  - FILL: s_ready_o=1.
    - Each cycle with s_valid_i&s_ready_o, the word is accepted.
    - Next cycle: we_o=1, wdata_o=word, waddr_o=addr_cnt, memory_selector_o=sel_cnt. Write latency is exactly 1 cycle.
    - addr_cnt increments per accepted word.
    - The word accepted at addr_cnt==last_addr ends the memory -> NEXT_MEM.
  - NEXT_MEM (1 cycle, s_ready_o=0):
    - If sel_cnt==NUM_MEMS-1 -> DONE.
    - Else sel_cnt+1, addr_cnt=0 -> FILL.
  - DONE (1 cycle): mem_updated_o=1 for exactly this cycle. It lands the cycle after the final we_o. Then -> IDLE.
- busy_o=1 in every state except IDLE.
- s_ready_o is registered. It deasserts the cycle after the last word of a memory is accepted, so no extra word is taken.
- we_o is a single-cycle pulse per accepted word. waddr_o, wdata_o and memory_selector_o hold their last values when we_o=0.
- Boundaries:
  - points_per_line_i=0 -> one word per memory.
  - addr_cnt never wraps: last_addr ≤ 2^ADDR_W-1 by construction.
  - Request (start_i or update edge) while busy -> pending=1. Only one pending request is held; extras are dropped. It is serviced right after the DONE->IDLE cycle.
  - start_i and an update edge in the same cycle count as one request.
  - s_valid_i low in FILL -> wait indefinitely (no macro).
  - points_per_line_i changes mid-load have no effect.
- Edge detect on update_mem_i uses a registered previous value, cleared to 0 on reset.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- With macro:
  - A stall counter counts consecutive FILL cycles with s_valid_i=0. It resets on any accept or state change.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, no mem_updated pulse, set error_o=1.
  - error_o stays set until rst_i. Pending is cleared on abort.
- Without macro: no stall counter, error_o tied 0, FILL waits forever.

Decomposition:
- Shared package: state encodings (IDLE=2'd0, FILL=2'd1, NEXT_MEM=2'd2, DONE=2'd3), ADDR_W/DATA_W/SEL_W defaults, DATA_W=17 word constant shared with timingCore.
- One natural sub-module: mem_loader_req_ctl.
  - Contains the update_mem_i edge detector and the pending-request latch.
  - Outputs a single req pulse to the FSM.

Test Plan:
- Reset, then start_i; points_per_line_i=3, NUM_MEMS=2, stream 8 words 0x100..0x107 with valid always high.
  - Required: we_o at sel0 addr0..3 then sel1 addr0..3, with data in order.
  - Required: mem_updated_o pulses exactly once, 1 cycle after the last we_o.
  - Required: busy_o drops the next cycle.
- Same load with s_valid_i toggling 1010.
  - Required: identical write sequence.
  - Required: s_ready_o=0 during the NEXT_MEM cycle, and no word is lost or duplicated.
- update_mem_i rises twice during a load.
  - Required: exactly one follow-up load starts right after IDLE is re-entered.
  - Required: exactly two mem_updated_o pulses in total.
- points_per_line_i=0, NUM_MEMS=1.
  - Required: one we_o at addr0, sel0, then mem_updated_o.
  - Required: points_per_line_i changed to 5 mid-load is ignored.
- rst_i asserted while in FILL after 2 words.
  - Required: next cycle all outputs 0, no mem_updated_o.
  - Required: a new start_i restarts at sel0 addr0.
- With LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16: valid held low 16 cycles in FILL.
  - Required: return to IDLE, error_o=1 sticky, no mem_updated_o.
  - Required: error_o cleared only by rst_i.
